irq_request_capture: RTL and testbench

//  Upstream stage of the 8:3 priority encoder. Synchronises 8 asynchronous

---
 rtl/irq_request_capture.sv | 154 +++++++++++++++
 tb/tb_irq_request_capture.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_request_capture.sv
// irq_request_capture: synchronises eight request lines, latches them as
// pending bits, presents the masked vector to the downstream 8:3 encoder and
// clears the serviced bit when the consumer acknowledges the encoded index.
module irq_request_capture #(
    parameter int SYNC_STAGES = 2,    // synchroniser depth per line, >= 2
    parameter bit EDGE_MODE   = 1'b1, // 1: rising edge sets pending, 0: level
    parameter int HOLDOFF_CYC = 1     // irq-low cycles after each ack, 0..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_in,
    input  logic [7:0] mask,
    input  logic       global_en,
    output logic [7:0] pend_vec,
    output logic       enc_en,
    input  logic [2:0] enc_idx,
    output logic       irq,
    input  logic       ack,
    output logic       ack_err,
    output logic [7:0] ovf,
    input  logic       ovf_clr,
    output logic [1:0] state_dbg
);

    // Handshake: irq (valid) stays high while in ASSERT; the consumer answers
    // with a one-cycle ack strobe naming enc_idx. The ack is accepted only if
    // it arrives in ASSERT and the named bit is currently visible in pend_vec;
    // any other ack is rejected, clears nothing and raises ack_err next cycle.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF_CYC);

    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] d_q;
    logic [7:0] s_vec;
    logic [7:0] set_vec;
    logic [7:0] clr_vec;
    logic [7:0] new_ovf;
    logic [7:0] pending_q;
    logic [7:0] ovf_q;
    logic       ack_err_q;
    logic       ack_ok;
    state_t     state_q;
    state_t     state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Synchroniser chain plus one extra flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            d_q <= '0;
        end else begin
            sync_q[0] <= req_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            d_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s_vec    = sync_q[SYNC_STAGES-1];
    assign set_vec  = EDGE_MODE ? (s_vec & ~d_q) : s_vec;
    assign pend_vec = pending_q & mask;
    assign ack_ok   = ack && (state_q == ASSERT) && pend_vec[enc_idx];
    assign clr_vec  = ack_ok ? (8'd1 << enc_idx) : 8'd0;
    // A level request that is still high is not an overflow, only a re-set.
    assign new_ovf  = EDGE_MODE ? (set_vec & pending_q & ~clr_vec) : 8'd0;

    // Pending bits: a fresh set beats a clear of the same bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= set_vec | (pending_q & ~clr_vec);
        end
    end

    // Sticky overflow flags; an overflow in the clear cycle survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else if (ovf_clr) begin
            ovf_q <= new_ovf;
        end else begin
            ovf_q <= ovf_q | new_ovf;
        end
    end

    // Registered one-cycle error pulse for a rejected ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_err_q <= 1'b0;
        end else begin
            ack_err_q <= ack && !ack_ok;
        end
    end

    // FSM state and holdoff counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next-state and holdoff counter update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (global_en && (pend_vec != 8'd0)) begin
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                if (ack_ok) begin
                    cnt_d   = HOLD_INIT;
                    state_d = (HOLD_INIT == 4'd0) ? IDLE : HOLDOFF;
                end else if (!ack && (!global_en || (pend_vec == 8'd0))) begin
                    state_d = IDLE;
                end
            end
            HOLDOFF: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign irq       = (state_q == ASSERT);
    assign enc_en    = (state_q == ASSERT);
    assign ack_err   = ack_err_q;
    assign ovf       = ovf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_irq_request_capture.sv
// Bench for irq_request_capture: an edge-mode instance (holdoff 1) and a
// level-mode instance (holdoff 2) run side by side against a reference model
// that tracks request history, pending set and irq phase with plain arithmetic.
module tb_irq_request_capture;

    localparam int SYNC = 2;

    typedef struct {
        logic [7:0] hist [SYNC+1]; // hist[k] = req sampled k+1 edges ago
        logic [7:0] pend;
        logic [7:0] ovf;
        logic       err;
        logic       irq;
        int         hold;          // remaining irq-low cycles after an ack
    } mdl_t;

    logic       clk;
    logic       rst_n = 1'b0;
    logic [7:0] mask = 8'hFF;
    logic       global_en = 1'b1;
    logic       ovf_clr = 1'b0;
    logic [7:0] req_a = 8'h00, req_b = 8'h00;
    logic [2:0] idx_a = 3'd0, idx_b = 3'd0;
    logic       ack_a = 1'b0, ack_b = 1'b0;

    logic [7:0] pend_a, pend_b, ovf_a, ovf_b;
    logic       enc_en_a, enc_en_b, irq_a, irq_b, err_a, err_b;
    logic [1:0] st_a, st_b;

    int total = 0;
    int bad = 0;
    mdl_t ma, mb;

    irq_request_capture #(.SYNC_STAGES(SYNC), .EDGE_MODE(1'b1), .HOLDOFF_CYC(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_in(req_a), .mask(mask), .global_en(global_en),
        .pend_vec(pend_a), .enc_en(enc_en_a), .enc_idx(idx_a), .irq(irq_a), .ack(ack_a),
        .ack_err(err_a), .ovf(ovf_a), .ovf_clr(ovf_clr), .state_dbg(st_a)
    );

    irq_request_capture #(.SYNC_STAGES(SYNC), .EDGE_MODE(1'b0), .HOLDOFF_CYC(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_in(req_b), .mask(mask), .global_en(global_en),
        .pend_vec(pend_b), .enc_en(enc_en_b), .enc_idx(idx_b), .irq(irq_b), .ack(ack_b),
        .ack_err(err_b), .ovf(ovf_b), .ovf_clr(ovf_clr), .state_dbg(st_b)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic mdl_t mreset();
        mdl_t m;
        for (int k = 0; k <= SYNC; k++) m.hist[k] = 8'h00;
        m.pend = 8'h00;
        m.ovf  = 8'h00;
        m.err  = 1'b0;
        m.irq  = 1'b0;
        m.hold = 0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit edge_mode, int hold_cyc,
                                   logic [7:0] req, logic [7:0] msk, logic gen,
                                   logic [2:0] idx, logic ack, logic oclr);
        mdl_t n = m;
        logic [7:0] now_hi = m.hist[SYNC-1];
        logic [7:0] was_hi = m.hist[SYNC];
        logic [7:0] setv = edge_mode ? (now_hi & ~was_hi) : now_hi;
        logic [7:0] pv = m.pend & msk;
        logic ok = ack && m.irq && pv[idx];
        logic [7:0] clr = 8'h00;
        logic [7:0] nov;
        if (ok) clr[idx] = 1'b1;
        nov = edge_mode ? (setv & m.pend & ~clr) : 8'h00;
        n.ovf = oclr ? nov : (m.ovf | nov);
        n.err = ack && !ok;
        if (m.irq) begin
            if (ok) begin
                n.irq  = 1'b0;
                n.hold = hold_cyc;
            end else if (!ack && (!gen || pv == 8'h00)) begin
                n.irq = 1'b0;
            end
        end else if (m.hold > 0) begin
            n.hold = m.hold - 1;
        end else if (gen && pv != 8'h00) begin
            n.irq = 1'b1;
        end
        n.pend = setv | (m.pend & ~clr);
        for (int k = SYNC; k > 0; k--) n.hist[k] = m.hist[k-1];
        n.hist[0] = req;
        return n;
    endfunction

    function automatic logic [2:0] prio(logic [7:0] v);
        logic [2:0] r = 3'd0;
        for (int k = 0; k < 8; k++) if (v[k]) r = 3'(k);
        return r;
    endfunction

    // Reference model advances on the same edges as the DUTs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= mreset();
            mb <= mreset();
        end else begin
            ma <= mstep(ma, 1'b1, 1, req_a, mask, global_en, idx_a, ack_a, ovf_clr);
            mb <= mstep(mb, 1'b0, 2, req_b, mask, global_en, idx_b, ack_b, ovf_clr);
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic auto_idx();
        idx_a = prio(ma.pend & mask);
        idx_b = prio(mb.pend & mask);
    endtask

    // One clock: sample at the falling edge, compare both DUTs to the model,
    // then present the encoder index the model expects.
    task automatic tick();
        @(negedge clk);
        chk("a_irq", {7'd0, irq_a}, {7'd0, ma.irq});
        chk("a_enc_en", {7'd0, enc_en_a}, {7'd0, ma.irq});
        chk("a_pend", pend_a, ma.pend & mask);
        chk("a_err", {7'd0, err_a}, {7'd0, ma.err});
        chk("a_ovf", ovf_a, ma.ovf);
        chk("b_irq", {7'd0, irq_b}, {7'd0, mb.irq});
        chk("b_enc_en", {7'd0, enc_en_b}, {7'd0, mb.irq});
        chk("b_pend", pend_b, mb.pend & mask);
        chk("b_err", {7'd0, err_b}, {7'd0, mb.err});
        chk("b_ovf", ovf_b, mb.ovf);
        auto_idx();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_irq_a", {7'd0, irq_a}, 8'h00);
        chk("rst_irq_b", {7'd0, irq_b}, 8'h00);
        chk("rst_pend_a", pend_a, 8'h00);
        chk("rst_pend_b", pend_b, 8'h00);
        chk("rst_ovf_a", ovf_a, 8'h00);
        req_a = 8'h00; req_b = 8'h00; ack_a = 1'b0; ack_b = 1'b0;
        mask = 8'hFF; global_en = 1'b1; ovf_clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        auto_idx();
    endtask

    // Directed steps followed by a randomised run.
    initial begin
        // Reset with all requests held high.
        req_a = 8'hFF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick(); chk("t1_pend_e1", pend_a, 8'h00);
        tick(); chk("t1_pend_e2", pend_a, 8'h00);
        tick(); chk("t1_pend_e3", pend_a, 8'hFF);
        tick(); chk("t1_irq_e4", {7'd0, irq_a}, 8'h01);
        do_reset();

        // Priority and ack with holdoff.
        req_a = 8'h22;
        tick(); req_a = 8'h00;
        tick();
        tick(); chk("t2_pend", pend_a, 8'h22);
        tick(); chk("t2_irq", {7'd0, irq_a}, 8'h01);
        ack_a = 1'b1;
        tick(); ack_a = 1'b0;
        chk("t2_pend_after_ack", pend_a, 8'h02);
        chk("t2_irq_holdoff", {7'd0, irq_a}, 8'h00);
        tick();
        tick(); chk("t2_irq_again", {7'd0, irq_a}, 8'h01);
        ack_a = 1'b1;
        tick(); ack_a = 1'b0;
        chk("t2_pend_empty", pend_a, 8'h00);
        repeat (3) tick();

        // Illegal acks.
        ack_a = 1'b1;
        tick(); ack_a = 1'b0;
        chk("t3_err_idle", {7'd0, err_a}, 8'h01);
        tick(); chk("t3_err_gone", {7'd0, err_a}, 8'h00);
        req_a = 8'h02;
        tick(); req_a = 8'h00;
        repeat (3) tick();
        ack_a = 1'b1; idx_a = 3'd3;
        tick(); ack_a = 1'b0;
        chk("t3_err_bad_idx", {7'd0, err_a}, 8'h01);
        chk("t3_pend_kept", pend_a, 8'h02);
        ack_a = 1'b1;
        tick(); ack_a = 1'b0;
        repeat (3) tick();
        do_reset();

        // Set beats clear, then overflow and its clear.
        req_a = 8'h08;
        tick(); req_a = 8'h00;
        tick(); req_a = 8'h08;
        tick(); req_a = 8'h00;
        tick(); ack_a = 1'b1;
        tick(); ack_a = 1'b0;
        chk("t4_pend_kept", pend_a, 8'h08);
        chk("t4_no_ovf", ovf_a, 8'h00);
        req_a = 8'h08;
        tick(); req_a = 8'h00;
        tick();
        tick(); chk("t4_ovf_set", ovf_a, 8'h08);
        repeat (2) tick();
        chk("t4_ovf_sticky", ovf_a, 8'h08);
        ovf_clr = 1'b1;
        tick(); ovf_clr = 1'b0;
        chk("t4_ovf_cleared", ovf_a, 8'h00);
        do_reset();

        // Mask and global enable.
        mask = 8'h00; req_a = 8'h10;
        tick(); req_a = 8'h00;
        repeat (4) tick();
        chk("t5_irq_masked", {7'd0, irq_a}, 8'h00);
        chk("t5_pend_masked", pend_a, 8'h00);
        mask = 8'hFF; auto_idx();
        tick();
        chk("t5_pend_unmasked", pend_a, 8'h10);
        chk("t5_irq_unmasked", {7'd0, irq_a}, 8'h01);
        global_en = 1'b0;
        tick(); chk("t5_irq_global_off", {7'd0, irq_a}, 8'h00);
        global_en = 1'b1;
        tick(); ack_a = 1'b1;
        tick(); ack_a = 1'b0;
        do_reset();

        // Level mode re-pend, then asynchronous reset mid-ASSERT.
        req_b = 8'h01;
        repeat (4) tick();
        chk("t6_irq_b", {7'd0, irq_b}, 8'h01);
        ack_b = 1'b1;
        tick(); ack_b = 1'b0;
        chk("t6_pend_b_repend", pend_b, 8'h01);
        chk("t6_irq_b_holdoff", {7'd0, irq_b}, 8'h00);
        repeat (2) tick();
        tick(); chk("t6_irq_b_again", {7'd0, irq_b}, 8'h01);
        chk("t6_ovf_b", ovf_b, 8'h00);
        do_reset();

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            tick();
            ack_a = 1'b0; ack_b = 1'b0; ovf_clr = 1'b0;
            req_a = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            if ($urandom_range(0, 3) == 0) req_b = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 15) == 0) mask = 8'($urandom) | 8'($urandom);
            global_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) ovf_clr = 1'b1;
            auto_idx();
            if ($urandom_range(0, 2) == 0) ack_a = 1'b1;
            if ($urandom_range(0, 2) == 0) ack_b = 1'b1;
            if ($urandom_range(0, 7) == 0) idx_a = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) idx_b = 3'($urandom_range(0, 7));
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
